// File: rtl/light_phase_scheduler.sv
// light_phase_scheduler: one-second timebase, sensor/button conditioning, walk latch
// and main/side lamp phase sequencing for a two-road intersection.
package light_phase_scheduler_pkg;
   typedef enum logic [2:0] {
      PH_MG, PH_MGX, PH_MY, PH_WALK, PH_SG, PH_SGX, PH_SY, PH_BAD
   } phase_t;
endpackage

module light_phase_scheduler
   import light_phase_scheduler_pkg::*;
#(
   parameter int TICK_CYCLES = 100_000_000,
   parameter int DEB_CYCLES  = 1_000_000,
   parameter int T_BASE      = 6,
   parameter int T_EXT       = 3,
   parameter int T_YEL       = 2,
   parameter int T_WALK      = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Sensor,
   input  logic       walkButton,
   output logic [2:0] main_rgy,
   output logic [2:0] side_rgy,
   output logic       walk_lamp,
   output logic       walk_pending,
   output logic [2:0] phase,
   output logic       tick
);
   localparam int PW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
   localparam int DW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;

   phase_t        state, state_nxt;
   logic [PW-1:0] presc;
   logic [3:0]    secs, dur;
   logic [DW-1:0] deb_cnt;
   logic [1:0]    s_sync, b_sync;
   logic          deb, deb_d, last, adv;

   always_comb begin
      state_nxt = state;
      dur = (state == PH_MGX || state == PH_SGX) ? 4'(T_EXT) :
            (state == PH_MY || state == PH_SY)   ? 4'(T_YEL) :
            (state == PH_WALK)                   ? 4'(T_WALK) : 4'(T_BASE);
      tick = presc == PW'(TICK_CYCLES - 1);
      last = tick && secs == dur - 4'd1;
      case (state)
         PH_MG:   if (last) state_nxt = s_sync[1] ? PH_MGX : PH_MY;
         PH_MGX:  if (last) state_nxt = PH_MY;
         PH_MY:   if (last) state_nxt = walk_pending ? PH_WALK : PH_SG;
         PH_WALK: if (last) state_nxt = PH_SG;
         PH_SG:   if (last) state_nxt = s_sync[1] ? PH_SGX : PH_SY;
         PH_SGX:  if (last) state_nxt = PH_SY;
         PH_SY:   if (last) state_nxt = PH_MG;
         default: state_nxt = PH_MG;
      endcase
      adv = state_nxt != state;
      main_rgy = (state inside {PH_MG, PH_MGX}) ? 3'b001 : (state == PH_MY) ? 3'b010 : 3'b100;
      side_rgy = (state inside {PH_SG, PH_SGX}) ? 3'b001 : (state == PH_SY) ? 3'b010 : 3'b100;
      walk_lamp = state == PH_WALK;
      phase = state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= PH_MG;
         presc        <= '0;
         secs         <= '0;
         deb_cnt      <= '0;
         s_sync       <= '0;
         b_sync       <= '0;
         deb          <= 1'b0;
         deb_d        <= 1'b0;
         walk_pending <= 1'b0;
      end else begin
         s_sync <= {s_sync[0], Sensor};
         b_sync <= {b_sync[0], walkButton};
         deb_d  <= deb;
         // stability count runs only while the synced button disagrees with the accepted level
         if (b_sync[1] == deb) deb_cnt <= '0;
         else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
            deb     <= b_sync[1];
            deb_cnt <= '0;
         end else deb_cnt <= deb_cnt + 1'b1;
         state <= state_nxt;
         presc <= (adv || tick) ? '0 : presc + 1'b1;
         secs  <= adv ? '0 : tick ? secs + 4'd1 : secs;
         walk_pending <= (adv && state_nxt == PH_WALK) ? 1'b0 :
                         (deb && !deb_d && state != PH_WALK) ? 1'b1 : walk_pending;
      end
   end
endmodule

// File: tb/tb_light_phase_scheduler.sv
// tb_light_phase_scheduler: randomized and directed stimulus checked every cycle
// against a cycle-counting behavioural model, plus hand-computed pinned expectations.
module tb_light_phase_scheduler;
   import light_phase_scheduler_pkg::*;
   localparam int TC = 4, DC = 3;
   localparam int TB = 6, TE = 3, TY = 2, TW = 3;

   logic clk = 0, rst = 1, Sensor = 0, walkButton = 0;
   logic [2:0] main_rgy, side_rgy, phase;
   logic walk_lamp, walk_pending, tick;
   int n_chk = 0, n_err = 0;
   bit chk_en = 0;

   light_phase_scheduler #(.TICK_CYCLES(TC), .DEB_CYCLES(DC)) dut (
      .clk(clk), .rst(rst), .Sensor(Sensor), .walkButton(walkButton),
      .main_rgy(main_rgy), .side_rgy(side_rgy), .walk_lamp(walk_lamp),
      .walk_pending(walk_pending), .phase(phase), .tick(tick)
   );

   always #5 clk = ~clk;

   function automatic int dur_of(int p);
      return (p == 1 || p == 5) ? TE : (p == 2 || p == 6) ? TY : (p == 3) ? TW : TB;
   endfunction

   function automatic int succ(int p, bit s, bit w);
      case (p)
         0: return s ? 1 : 2;
         1: return 2;
         2: return w ? 3 : 4;
         3: return 4;
         4: return s ? 5 : 6;
         5: return 6;
         default: return 0;
      endcase
   endfunction

   function automatic logic [2:0] lamp(int p, bit side);
      if (!side) return (p <= 1) ? 3'b001 : (p == 2) ? 3'b010 : 3'b100;
      return (p == 4 || p == 5) ? 3'b001 : (p == 6) ? 3'b010 : 3'b100;
   endfunction

   // model: phase plus cycles elapsed in it; raw inputs delayed two edges stand in for the synchronizers
   int m_ph = 0, m_cyc = 0, m_nph = 0;
   bit m_pend = 0, m_deb = 0, m_deb_d = 0, s_h1 = 0, s_h2 = 0, b_h1 = 0, b_h2 = 0;
   bit m_fin, m_rise, m_all;
   bit bq[$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ph = 0; m_cyc = 0; m_pend = 0; m_deb = 0; m_deb_d = 0;
         s_h1 = 0; s_h2 = 0; b_h1 = 0; b_h2 = 0;
         bq.delete();
      end else begin
         m_fin  = m_cyc == dur_of(m_ph) * TC - 1;
         m_rise = m_deb && !m_deb_d;
         m_nph  = m_fin ? succ(m_ph, s_h2, m_pend) : m_ph;
         if (m_fin && m_nph == 3) m_pend = 0;
         else if (m_rise && m_ph != 3) m_pend = 1;
         m_deb_d = m_deb;
         bq.push_back(b_h2);
         if (bq.size() > DC) void'(bq.pop_front());
         if (bq.size() == DC && b_h2 != m_deb) begin
            m_all = 1;
            foreach (bq[i]) if (bq[i] != b_h2) m_all = 0;
            if (m_all) m_deb = b_h2;
         end
         m_cyc = m_fin ? 0 : m_cyc + 1;
         m_ph  = m_nph;
         s_h2 = s_h1; s_h1 = Sensor;
         b_h2 = b_h1; b_h1 = walkButton;
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) if (chk_en) begin
      chk("phase", 32'(phase), 32'(m_ph));
      chk("main_rgy", 32'(main_rgy), 32'(lamp(m_ph, 0)));
      chk("side_rgy", 32'(side_rgy), 32'(lamp(m_ph, 1)));
      chk("walk_lamp", 32'(walk_lamp), 32'(m_ph == 3));
      chk("walk_pending", 32'(walk_pending), 32'(m_pend));
      chk("tick", 32'(tick), 32'(m_cyc % TC == TC - 1));
   end

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(int n);
      walkButton = 1;
      cyc(n);
      walkButton = 0;
   endtask

   initial begin
      chk_en = 1;
      cyc(2);
      chk("rst_main", 32'(main_rgy), 32'b001);
      chk("rst_side", 32'(side_rgy), 32'b100);
      chk("rst_phase", 32'(phase), 0);
      chk("rst_tick", 32'(tick), 0);
      rst = 0;
      // idle cycle: MG 24, MY 8, SG 24, SY 8
      cyc(3);  chk("first_tick", 32'(tick), 1);
      cyc(1);  chk("tick_gap", 32'(tick), 0);
      cyc(19); chk("idle_mg_end", 32'(phase), 0);
      cyc(1);  chk("idle_my", 32'(phase), 2);
      cyc(8);  chk("idle_sg", 32'(phase), 4);
      cyc(24); chk("idle_sy", 32'(phase), 6);
      cyc(8);  chk("idle_wrap", 32'(phase), 0);
      // sensor extension on both roads
      Sensor = 1;
      cyc(24); chk("ext_mgx", 32'(phase), 1);
      chk("ext_mgx_main", 32'(main_rgy), 32'b001);
      cyc(12); chk("ext_my", 32'(phase), 2);
      cyc(32); chk("ext_sgx", 32'(phase), 5);
      chk("ext_sgx_side", 32'(side_rgy), 32'b001);
      cyc(12); chk("ext_sy", 32'(phase), 6);
      Sensor = 0;
      cyc(8);
      // debounce: short glitch rejected, clean press latched
      press(2);
      cyc(8);  chk("glitch_pending", 32'(walk_pending), 0);
      press(6); chk("press_pending", 32'(walk_pending), 1);
      cyc(16); chk("walk_phase", 32'(phase), 3);
      chk("walk_main", 32'(main_rgy), 32'b100);
      chk("walk_side", 32'(side_rgy), 32'b100);
      chk("walk_lamp_on", 32'(walk_lamp), 1);
      chk("walk_clear", 32'(walk_pending), 0);
      // press inside WALK ignored, press inside SG served after next MY
      cyc(2);
      press(6);
      cyc(4);  chk("after_walk_sg", 32'(phase), 4);
      chk("walk_press_ignored", 32'(walk_pending), 0);
      cyc(4);
      press(6); chk("sg_press_pending", 32'(walk_pending), 1);
      cyc(54); chk("served_walk", 32'(phase), 3);
      // asynchronous reset mid-WALK
      cyc(6);
      #2 rst = 1;
      #1;
      chk("async_main", 32'(main_rgy), 32'b001);
      chk("async_side", 32'(side_rgy), 32'b100);
      chk("async_walk_lamp", 32'(walk_lamp), 0);
      chk("async_phase", 32'(phase), 0);
      @(negedge clk) rst = 0;
      cyc(23); chk("post_rst_mg", 32'(phase), 0);
      cyc(1);  chk("post_rst_my", 32'(phase), 2);
      // randomized traffic with occasional async reset
      for (int i = 0; i < 1500; i++) begin
         Sensor = 1'($urandom_range(0, 1));
         walkButton = 1'($urandom_range(0, 1));
         cyc($urandom_range(1, 8));
         if ($urandom_range(0, 199) == 0) begin
            #2 rst = 1;
            @(negedge clk) rst = 0;
         end
      end
      // illegal phase code recovers to MG
      chk_en = 0;
      Sensor = 0;
      walkButton = 0;
      @(negedge clk);
      force dut.state = PH_BAD;
      #1;
      chk("ill_phase", 32'(phase), 7);
      chk("ill_main", 32'(main_rgy), 32'b100);
      chk("ill_side", 32'(side_rgy), 32'b100);
      release dut.state;
      @(negedge clk);
      chk("ill_recover", 32'(phase), 0);
      chk("ill_recover_main", 32'(main_rgy), 32'b001);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
